// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
package alu_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned OPD_W  = 8;
  localparam int unsigned INST_W = OPC_W + OPD_W;

  // Opcode the ALU treats as "hold"; also driven whenever the sequencer is not executing.
  localparam logic [OPC_W-1:0] OP_NOP = 4'h8;

  // 0-12 are executed by the external ALU (8 = nop, 9 = clear is handled here);
  // 13-15 are local to the sequencer.
  typedef enum logic [OPC_W-1:0] {
    OP_PASSB = 4'h0,
    OP_PASSA = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_INC   = 4'h5,
    OP_DEC   = 4'h6,
    OP_OR    = 4'h7,
    OP_HOLD  = 4'h8,
    OP_CLR   = 4'h9,
    OP_XOR   = 4'hA,
    OP_NOT   = 4'hB,
    OP_SHL   = 4'hC,
    OP_BCLR  = 4'hD,
    OP_BSET  = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  // One-hot mask selecting a single accumulator bit.
  function automatic logic [OPD_W-1:0] bit_mask(input logic [2:0] idx);
    return OPD_W'(1) << idx;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus bundle between the sequencer, its program memory and the ALU.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) ();

  logic              start;
  logic [ADDR_W-1:0] prog_addr;
  logic [INST_W-1:0] prog_data;
  logic [OPC_W-1:0]  inst;
  logic [OPD_W-1:0]  a;
  logic [OPD_W-1:0]  b;
  logic [OPD_W:0]    ans;
  logic [OPD_W-1:0]  acc;
  logic              carry_flag;
  logic              zero_flag;
  logic              busy;
  logic              done;

  // Sequencer side.
  modport master (
    input  start, prog_data, ans,
    output prog_addr, inst, a, b, acc, carry_flag, zero_flag, busy, done
  );

  // Environment side: program memory, ALU and controller.
  modport slave (
    output start, prog_data, ans,
    input  prog_addr, inst, a, b, acc, carry_flag, zero_flag, busy, done
  );

endinterface

// File: rtl/alu_seq.sv
// Instruction sequencer and accumulator feeding an external 8-bit ALU.
// Each instruction takes FETCH, DECODE and EXEC; acc/flags only move at the end of EXEC.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input logic       clk,
  input logic       reset,
  alu_seq_if.master bus
);

  localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_ir;
  logic [OPD_W-1:0]  r_acc;
  logic              r_carry;
  logic              r_zero;

  opcode_e           w_opc;
  logic [OPD_W-1:0]  w_opd;
  logic [OPD_W-1:0]  w_acc_d;
  logic              w_carry_d;

  assign w_opc = opcode_e'(r_ir[INST_W-1:OPD_W]);
  assign w_opd = r_ir[OPD_W-1:0];

  // Write-back value for the instruction held in ir, using the ALU result where it applies.
  always_comb begin
    w_acc_d   = r_acc;
    w_carry_d = r_carry;
    case (w_opc)
      OP_HOLD, OP_HALT: ;
      OP_CLR: begin
        w_acc_d   = '0;
        w_carry_d = 1'b0;
      end
      OP_BCLR: w_acc_d = r_acc & ~bit_mask(w_opd[2:0]);
      OP_BSET: w_acc_d = r_acc | bit_mask(w_opd[2:0]);
      default: w_acc_d = bus.ans[OPD_W-1:0];
    endcase
    if (w_opc inside {OP_ADD, OP_SUB, OP_INC, OP_DEC}) begin
      w_carry_d = bus.ans[OPD_W];
    end
  end

  // Sequencer FSM with program counter, instruction register, accumulator and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= {OP_NOP, {OPD_W{1'b0}}};
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_HALT: begin
          if (bus.start) begin
            r_pc    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          r_ir    <= bus.prog_data;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (w_opc == OP_HALT) begin
            r_state <= ST_HALT;
          end else begin
            r_acc   <= w_acc_d;
            r_carry <= w_carry_d;
            r_zero  <= (w_acc_d == '0);
            // The last word ends the program; pc stays put rather than wrapping to 0.
            if (r_pc == PC_LAST) begin
              r_state <= ST_HALT;
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bit ops are local, so the ALU is told to hold while they execute.
  assign bus.inst = ((r_state == ST_EXEC) && (w_opc != OP_BCLR) && (w_opc != OP_BSET))
                    ? r_ir[INST_W-1:OPD_W] : OP_NOP;
  assign bus.a          = w_opd;
  assign bus.b          = r_acc;
  assign bus.prog_addr  = r_pc;
  assign bus.acc        = r_acc;
  assign bus.carry_flag = r_carry;
  assign bus.zero_flag  = r_zero;
  assign bus.busy       = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC);
  assign bus.done       = (r_state == ST_HALT);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed programs, scoreboard of expected results.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.ADDR_W(4)) if4 ();
  alu_seq_if #(.ADDR_W(2)) if2 ();

  alu_seq #(.ADDR_W(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4.master));
  alu_seq #(.ADDR_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.master));

  logic [11:0] mem4 [16];
  logic [11:0] mem2 [4];

  // Synchronous program memories.
  always_ff @(posedge clk) if4.prog_data <= mem4[if4.prog_addr];
  always_ff @(posedge clk) if2.prog_data <= mem2[if2.prog_addr];

  // Reference ALU: subtract is b - a with borrow in bit 8.
  function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    case (op)
      4'h0:    return {1'b0, b};
      4'h1:    return {1'b0, a};
      4'h2:    return {1'b0, b} + {1'b0, a};
      4'h3:    return {1'b0, b} - {1'b0, a};
      4'h4:    return {1'b0, a & b};
      4'h5:    return {1'b0, b} + 9'd1;
      4'h6:    return {1'b0, b} - 9'd1;
      4'h7:    return {1'b0, a | b};
      4'hA:    return {1'b0, a ^ b};
      4'hB:    return {1'b0, ~b};
      4'hC:    return {b, 1'b0};
      default: return {1'b0, b};
    endcase
  endfunction

  always_comb if4.ans = alu_model(if4.inst, if4.a, if4.b);
  always_comb if2.ans = alu_model(if2.inst, if2.a, if2.b);

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc;
  logic wrapped;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear4();
    for (int i = 0; i < 16; i++) mem4[i] = 12'hF00;
  endtask

  // Pulse start on the 4-bit instance and count cycles until done (bounded).
  task automatic run4(output int n);
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    n = 0;
    while (!if4.done && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset     = 1'b0;
    if4.start = 1'b0;
    if2.start = 1'b0;
    clear4();
    for (int i = 0; i < 4; i++) mem2[i] = 12'hF00;

    // Reset values
    sb_push("rst_acc_c_z", 32'h000);
    sb_push("rst_inst_a_b", 32'h80000);
    sb_push("rst_addr_busy_done", 32'h000);
    sb_push("rst_addr2_busy2", 32'h0);
    #12;
    check_next({if4.acc, if4.carry_flag, if4.zero_flag});
    check_next({if4.inst, if4.a, if4.b});
    check_next({if4.prog_addr, if4.busy, if4.done});
    check_next({if2.prog_addr, if2.busy});
    reset = 1'b1;
    tick();

    // 5 + 3
    clear4();
    mem4[0] = 12'h105; mem4[1] = 12'h203; mem4[2] = 12'hF00;
    sb_push("add_latency", 32'd9);
    sb_push("add_acc", 32'h08);
    sb_push("add_carry", 32'h0);
    sb_push("add_zero", 32'h0);
    run4(cyc);
    check_next(cyc);
    check_next(if4.acc);
    check_next(if4.carry_flag);
    check_next(if4.zero_flag);

    // 0xFF + 1 overflows to zero with carry; restart from HALT
    clear4();
    mem4[0] = 12'h1FF; mem4[1] = 12'h201; mem4[2] = 12'hF00;
    sb_push("ovf_latency", 32'd9);
    sb_push("ovf_acc", 32'h00);
    sb_push("ovf_carry", 32'h1);
    sb_push("ovf_zero", 32'h1);
    run4(cyc);
    check_next(cyc);
    check_next(if4.acc);
    check_next(if4.carry_flag);
    check_next(if4.zero_flag);

    // 3 - 5 borrows
    clear4();
    mem4[0] = 12'h103; mem4[1] = 12'h305;
    sb_push("sub_borrow_acc", 32'hFE);
    sb_push("sub_borrow_carry", 32'h1);
    sb_push("sub_borrow_zero", 32'h0);
    run4(cyc);
    check_next(if4.acc);
    check_next(if4.carry_flag);
    check_next(if4.zero_flag);

    // 9 - 5 does not borrow
    mem4[0] = 12'h109;
    sb_push("sub_acc", 32'h04);
    sb_push("sub_carry", 32'h0);
    run4(cyc);
    check_next(if4.acc);
    check_next(if4.carry_flag);

    // Clear, set bit 7, set bit 0, clear bit 7
    clear4();
    mem4[0] = 12'h900; mem4[1] = 12'hE07; mem4[2] = 12'hE00; mem4[3] = 12'hD07;
    sb_push("clr_acc", 32'h00);
    sb_push("clr_zero", 32'h1);
    sb_push("bset7_inst", 32'h8);
    sb_push("bset7_acc", 32'h80);
    sb_push("bset0_inst", 32'h8);
    sb_push("bset0_acc", 32'h81);
    sb_push("bclr7_acc", 32'h01);
    sb_push("bitop_done", 32'h1);
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    repeat (3) tick();
    check_next(if4.acc);
    check_next(if4.zero_flag);
    repeat (2) tick();
    check_next(if4.inst);
    tick();
    check_next(if4.acc);
    repeat (2) tick();
    check_next(if4.inst);
    tick();
    check_next(if4.acc);
    repeat (3) tick();
    check_next(if4.acc);
    repeat (3) tick();
    check_next(if4.done);

    // ADDR_W=2, no halt word, start pulse while busy is ignored
    mem2[0] = 12'h101; mem2[1] = 12'h202; mem2[2] = 12'h203; mem2[3] = 12'h204;
    sb_push("nohalt_latency", 32'd12);
    sb_push("nohalt_acc", 32'h0A);
    sb_push("nohalt_addr", 32'h3);
    sb_push("nohalt_no_wrap", 32'h0);
    wrapped = 1'b0;
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    cyc = 0;
    repeat (4) begin
      tick();
      cyc++;
    end
    if2.start = 1'b1;
    tick();
    cyc++;
    if2.start = 1'b0;
    while (!if2.done && cyc < 200) begin
      tick();
      cyc++;
      if (cyc > 9 && if2.prog_addr == 2'd0) wrapped = 1'b1;
    end
    check_next(cyc);
    check_next(if2.acc);
    check_next(if2.prog_addr);
    check_next(wrapped);

    // Reset during the EXEC cycle of an add
    clear4();
    mem4[0] = 12'h105; mem4[1] = 12'h203;
    sb_push("mid_b_before", 32'h05);
    sb_push("mid_rst_acc", 32'h00);
    sb_push("mid_rst_inst", 32'h8);
    sb_push("mid_rst_busy_addr_b", 32'h000);
    sb_push("mid_rst_hold_acc", 32'h00);
    sb_push("rerun_latency", 32'd9);
    sb_push("rerun_acc", 32'h08);
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    repeat (5) tick();
    check_next(if4.b);
    #2 reset = 1'b0;
    #1;
    check_next(if4.acc);
    check_next(if4.inst);
    check_next({if4.busy, if4.prog_addr, if4.b});
    tick();
    check_next(if4.acc);
    #2 reset = 1'b1;
    run4(cyc);
    check_next(cyc);
    check_next(if4.acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
